axi_st_rr_src_arbiter: RTL and testbench



---
 rtl/axi_st_rr_src_arbiter.sv | 166 ++++++++++++++++
 tb/tb_axi_st_rr_src_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_st_rr_src_arbiter.sv
// Round-robin arbiter sharing one AXI-ST transmit channel among NUM_SRC sources.
// Each grant holds for a burst of up to MAX_BURST beats. The output beat is
// registered and sustains one beat per cycle.
// Optional macro AXI_ST_ARB_DEBUG_EN adds the arb_debug_status port and its counters.
module axi_st_rr_src_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned ID_W       = $clog2(NUM_SRC)
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr,
  input  logic                          enable,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata,
  input  logic [NUM_SRC-1:0]            src_tvalid,
  output logic [NUM_SRC-1:0]            src_tready,
  output logic [DATA_WIDTH-1:0]         user_tdata,
  output logic                          user_tvalid,
  input  logic                          user_tready,
  output logic [ID_W-1:0]               user_tsrc
`ifdef AXI_ST_ARB_DEBUG_EN
  ,
  output logic [31:0]                   arb_debug_status
`endif
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state;
  logic [ID_W-1:0]         ptr;
  logic [ID_W-1:0]         holder;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_inc;

  logic                    load_en;
  logic                    any_valid;
  logic                    accept;
  logic                    hold_ok;
  logic [ID_W-1:0]         rr_sel;
  logic [ID_W-1:0]         sel;
  logic [DATA_WIDTH-1:0]   sel_data;

  assign load_en   = enable & ~rst_wr & (~user_tvalid | user_tready);
  assign any_valid = |src_tvalid;
  assign accept    = load_en & any_valid;
  assign cnt_inc   = cnt + CNT_W'(1);

  // Grant selection: lock holder while it stays valid, else round-robin from ptr+1
  always_comb begin
    int unsigned idx;
    idx     = 0;
    rr_sel  = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (src_tvalid[idx]) rr_sel = ID_W'(idx);
    end
    hold_ok = (state == LOCKED) && src_tvalid[holder];
    sel     = hold_ok ? holder : rr_sel;
  end

  // Per-source ready: only the selected source, only when a beat can be loaded
  always_comb begin
    src_tready = '0;
    if (accept) src_tready[sel] = 1'b1;
  end

  // Data mux for the selected source, feeding the output register only
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (ID_W'(k) == sel) sel_data = src_tdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Output stage, round-robin pointer and burst-lock state machine
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      user_tdata  <= '0;
      user_tvalid <= 1'b0;
      user_tsrc   <= '0;
      ptr         <= ID_W'(NUM_SRC - 1);
      state       <= IDLE;
      holder      <= '0;
      cnt         <= '0;
    end else begin
      if (accept) begin
        user_tdata  <= sel_data;
        user_tvalid <= 1'b1;
        user_tsrc   <= sel;
        ptr         <= sel;
      end else if (user_tready) begin
        user_tvalid <= 1'b0;
      end

      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept && (MAX_BURST > 1)) begin
              state  <= LOCKED;
              holder <= sel;
              cnt    <= CNT_W'(1);
            end
          end
          LOCKED: begin
            if (load_en) begin
              if (hold_ok) begin
                if (cnt_inc == CNT_W'(MAX_BURST)) begin
                  state <= IDLE;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt_inc;
                end
              end else if (any_valid) begin
                // holder dropped: relock on the source granted this cycle
                holder <= sel;
                cnt    <= CNT_W'(1);
              end else begin
                state <= IDLE;
                cnt   <= '0;
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

`ifdef AXI_ST_ARB_DEBUG_EN
  logic [7:0]      dbg_src0_cnt;
  logic [7:0]      dbg_rel_cnt;
  logic [ID_W-1:0] dbg_last_id;
  logic            release_evt;

  assign release_evt = (state == LOCKED) && load_en && !src_tvalid[holder];

  // Saturating debug counters and last-grant capture
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      dbg_src0_cnt <= '0;
      dbg_rel_cnt  <= '0;
      dbg_last_id  <= '0;
    end else begin
      if (accept && (sel == '0) && (dbg_src0_cnt != 8'hFF))
        dbg_src0_cnt <= dbg_src0_cnt + 8'd1;
      if (release_evt && (dbg_rel_cnt != 8'hFF))
        dbg_rel_cnt <= dbg_rel_cnt + 8'd1;
      if (accept)
        dbg_last_id <= sel;
    end
  end

  assign arb_debug_status = {12'd0, (state == LOCKED), 3'(dbg_last_id),
                             dbg_rel_cnt, dbg_src0_cnt};
`endif

endmodule

// File: tb/tb_axi_st_rr_src_arbiter.sv
// Directed self-checking bench for axi_st_rr_src_arbiter.
// Instance a uses MAX_BURST=4 and instance b uses MAX_BURST=1.
module tb_axi_st_rr_src_arbiter;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_wr;

  logic             a_enable, a_user_tready, a_user_tvalid;
  logic [NS*DW-1:0] a_tdata;
  logic [NS-1:0]    a_tvalid, a_tready;
  logic [DW-1:0]    a_user_tdata;
  logic [1:0]       a_tsrc;

  logic             b_enable, b_user_tready, b_user_tvalid;
  logic [NS*DW-1:0] b_tdata;
  logic [NS-1:0]    b_tvalid, b_tready;
  logic [DW-1:0]    b_user_tdata;
  logic [1:0]       b_tsrc;
`ifdef AXI_ST_ARB_DEBUG_EN
  logic [31:0]      a_dbg, b_dbg;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_st_rr_src_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_BURST(4)) u_a (
    .clk_wr(clk), .rst_wr(rst_wr), .enable(a_enable),
    .src_tdata(a_tdata), .src_tvalid(a_tvalid), .src_tready(a_tready),
    .user_tdata(a_user_tdata), .user_tvalid(a_user_tvalid),
    .user_tready(a_user_tready), .user_tsrc(a_tsrc)
`ifdef AXI_ST_ARB_DEBUG_EN
    , .arb_debug_status(a_dbg)
`endif
  );

  axi_st_rr_src_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_BURST(1)) u_b (
    .clk_wr(clk), .rst_wr(rst_wr), .enable(b_enable),
    .src_tdata(b_tdata), .src_tvalid(b_tvalid), .src_tready(b_tready),
    .user_tdata(b_user_tdata), .user_tvalid(b_user_tvalid),
    .user_tready(b_user_tready), .user_tsrc(b_tsrc)
`ifdef AXI_ST_ARB_DEBUG_EN
    , .arb_debug_status(b_dbg)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_wr        = 1'b1;
    a_enable      = 1'b1;
    a_user_tready = 1'b1;
    a_tvalid      = 4'hF;
    b_enable      = 1'b1;
    b_user_tready = 1'b1;
    b_tvalid      = 4'h0;
    for (int i = 0; i < NS; i++) begin
      a_tdata[i*DW +: DW] = 32'h1111_1111 * (i + 1);
      b_tdata[i*DW +: DW] = 32'hB000_0000 + i;
    end

    // reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tvalid", a_user_tvalid, 0);
      chk("rst_tready", a_tready, 0);
    end
    chk("rst_tdata", a_user_tdata, 0);
    chk("rst_tsrc", a_tsrc, 0);
`ifdef AXI_ST_ARB_DEBUG_EN
    chk("rst_dbg", a_dbg, 0);
`endif
    rst_wr = 1'b0;
    #1;
    chk("first_ready", a_tready, 4'b0001);

    // bursts of four: 0,0,0,0,1,1,1,1,2,2 with no idle cycles
    for (int b = 0; b < 10; b++) begin
      step();
      chk("burst_tvalid", a_user_tvalid, 1);
      chk("burst_tsrc", a_tsrc, b / 4);
      chk("burst_tdata", a_user_tdata, 32'h1111_1111 * (b / 4 + 1));
    end

    // holder 2 drops after 2 beats, source 0 takes over with no bubble
    a_tvalid = 4'b0001;
    #1;
    chk("rel_ready", a_tready, 4'b0001);
    step();
    chk("rel_tvalid", a_user_tvalid, 1);
    chk("rel_tsrc", a_tsrc, 0);
`ifdef AXI_ST_ARB_DEBUG_EN
    chk("rel_dbg_cnt", a_dbg[15:8], 1);
    chk("rel_dbg_src0", a_dbg[7:0], 5);
    chk("rel_dbg_locked", a_dbg[19], 1);
`endif

    // backpressure with 0xA5 beat held
    a_tdata[0 +: DW] = 32'hA5A5_A5A5;
    step();
    chk("bp_load", a_user_tdata, 32'hA5A5_A5A5);
    a_user_tready = 1'b0;
    a_tdata[0 +: DW] = 32'h5A5A_0001;
    #1;
    chk("bp_ready0", a_tready, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_data", a_user_tdata, 32'hA5A5_A5A5);
      chk("bp_hold_valid", a_user_tvalid, 1);
      chk("bp_hold_ready", a_tready, 0);
    end
    a_user_tready = 1'b1;
    #1;
    chk("bp_release_ready", a_tready, 4'b0001);
    step();
    chk("bp_next_data", a_user_tdata, 32'h5A5A_0001);
    chk("bp_next_valid", a_user_tvalid, 1);

    // quiesce: held beat drains, nothing new granted
    a_enable      = 1'b0;
    a_user_tready = 1'b0;
    a_tvalid      = 4'b0010;
    #1;
    chk("q_ready_off", a_tready, 0);
    step();
    chk("q_hold_valid", a_user_tvalid, 1);
    chk("q_hold_data", a_user_tdata, 32'h5A5A_0001);
    a_user_tready = 1'b1;
    #1;
    chk("q_ready_off2", a_tready, 0);
    step();
    chk("q_drained", a_user_tvalid, 0);
    step();
    chk("q_idle", a_user_tvalid, 0);
    a_enable = 1'b1;
    a_tvalid = 4'hF;
    #1;
    chk("q_resume_ready", a_tready, 4'b0010);
    step();
    chk("q_resume_tsrc", a_tsrc, 1);
    chk("q_resume_data", a_user_tdata, 32'h2222_2222);

    // 300 beats from source 0 only
    a_tvalid = 4'b0001;
    for (int i = 0; i < 300; i++) step();
    chk("sat_tsrc", a_tsrc, 0);
    chk("sat_tvalid", a_user_tvalid, 1);
`ifdef AXI_ST_ARB_DEBUG_EN
    chk("sat_dbg", a_dbg, 32'h0000_02FF);
`endif

    // reset mid-burst discards the held beat
    step();
    a_user_tready = 1'b0;
    rst_wr = 1'b1;
    #1;
    chk("mrst_ready", a_tready, 0);
    step();
    chk("mrst_tvalid", a_user_tvalid, 0);
    chk("mrst_tdata", a_user_tdata, 0);
    chk("mrst_tsrc", a_tsrc, 0);
`ifdef AXI_ST_ARB_DEBUG_EN
    chk("mrst_dbg", a_dbg, 0);
`endif
    rst_wr = 1'b0;

    // per-beat round-robin with MAX_BURST=1
    b_tvalid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr1_ready", b_tready, (i % 2 == 0) ? 4'b0010 : 4'b1000);
      step();
      chk("rr1_tsrc", b_tsrc, (i % 2 == 0) ? 1 : 3);
      chk("rr1_data", b_user_tdata, (i % 2 == 0) ? 32'hB000_0001 : 32'hB000_0003);
    end
`ifdef AXI_ST_ARB_DEBUG_EN
    chk("rr1_never_locked", b_dbg[19], 0);
    chk("rr1_no_release", b_dbg[15:8], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
